fp32_mul_result_queue: RTL and testbench

- Downstream stage of the combinational single-precision multiplier; consumes its 32-bit result plus overflow/underflow flags.
- Applies IEEE-754 exception fix-up (overflow to signed infinity, underflow to signed zero).
- Buffers results in a small FIFO with valid/ready handshake on both sides.
- Keeps sticky exception flags for software/controller readout.

---
 rtl/fp32_mul_result_queue.sv | 121 ++++++++++++
 tb/tb_fp32_mul_result_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_result_queue.sv
// Result queue behind the fp32 multiplier: IEEE exception fix-up, valid/ready FIFO, sticky flags.
// Define FPMUL_RESULT_STATS_EN to add saturating overflow/underflow event counters.
module fp32_mul_result_queue #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_result,
    input  logic          in_overflow,
    input  logic          in_underflow,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [1:0]    out_flags,
    output logic          sticky_ovf,
    output logic          sticky_unf,
    input  logic          flag_clear,
    output logic [AW:0]   count
`ifdef FPMUL_RESULT_STATS_EN
    ,
    output logic [15:0]   ovf_cnt,
    output logic [15:0]   unf_cnt
`endif
);

    logic [33:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   fixed_data;
    logic          push;
    logic          pop;

    assign in_ready  = (count != (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fixed_data = in_result;
        if (in_overflow) begin
            fixed_data = {in_result[31], 8'hFF, 23'h0};
        end else if (in_underflow) begin
            fixed_data = {in_result[31], 31'h0};
        end
    end

    // NOTE: the storage array has no reset; out_valid gates the head so stale words never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_overflow, in_underflow, fixed_data};
        end
    end

    assign out_data  = out_valid ? mem[rd_ptr][31:0]  : 32'h0;
    assign out_flags = out_valid ? mem[rd_ptr][33:32] : 2'b00;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    // A setting push outranks flag_clear so no event is lost in the clear cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else begin
            if (push && in_overflow) begin
                sticky_ovf <= 1'b1;
            end else if (flag_clear) begin
                sticky_ovf <= 1'b0;
            end
            if (push && in_underflow) begin
                sticky_unf <= 1'b1;
            end else if (flag_clear) begin
                sticky_unf <= 1'b0;
            end
        end
    end

`ifdef FPMUL_RESULT_STATS_EN
    // Counters are the opposite of the sticky bits: clear outranks an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt <= 16'h0;
            unf_cnt <= 16'h0;
        end else if (flag_clear) begin
            ovf_cnt <= 16'h0;
            unf_cnt <= 16'h0;
        end else begin
            if (push && in_overflow && ovf_cnt != 16'hFFFF) begin
                ovf_cnt <= ovf_cnt + 16'h1;
            end
            if (push && in_underflow && unf_cnt != 16'hFFFF) begin
                unf_cnt <= unf_cnt + 16'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp32_mul_result_queue.sv
// Directed bench for fp32_mul_result_queue (DEPTH=4); also covers FPMUL_RESULT_STATS_EN when defined.
module tb_fp32_mul_result_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_underflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_flags;
    logic        sticky_ovf;
    logic        sticky_unf;
    logic        flag_clear;
    logic [2:0]  count;
`ifdef FPMUL_RESULT_STATS_EN
    logic [15:0] ovf_cnt;
    logic [15:0] unf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp32_mul_result_queue #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .sticky_ovf   (sticky_ovf),
        .sticky_unf   (sticky_unf),
        .flag_clear   (flag_clear),
        .count        (count)
`ifdef FPMUL_RESULT_STATS_EN
        ,
        .ovf_cnt      (ovf_cnt),
        .unf_cnt      (unf_cnt)
`endif
    );

    task automatic check(input string tag, input logic [33:0] observed, input logic [33:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Outputs are examined 1 time unit after the rising edge, once state has settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic o, input logic u);
        in_valid     = v;
        in_result    = d;
        in_overflow  = o;
        in_underflow = u;
    endtask

    logic [31:0] f_in   [4] = '{32'h3F800000, 32'h80000010, 32'h12345678, 32'h40000000};
    logic        f_ovf  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        f_unf  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] f_exp  [4] = '{32'h3F800000, 32'h80000000, 32'h7F800000, 32'h40000000};
    logic [1:0]  f_flg  [4] = '{2'b00, 2'b01, 2'b11, 2'b00};

    initial begin
        rst        = 1'b1;
        out_ready  = 1'b0;
        flag_clear = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        rst = 1'b0;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        check("rst_sticky", {sticky_ovf, sticky_unf}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_flags", out_flags, 0);

        // Plain value, consumer stalled.
        drive(1'b1, 32'h40400000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("p1_out_valid", out_valid, 1);
        check("p1_out_data", out_data, 32'h40400000);
        check("p1_out_flags", out_flags, 2'b00);
        check("p1_count", count, 1);
        tick();
        check("p1_hold_data", out_data, 32'h40400000);

        // Overflow push while popping 3.0: head becomes -inf.
        out_ready = 1'b1;
        drive(1'b1, 32'hC1234567, 1'b1, 1'b0);
        tick();
        check("ovf_out_data", out_data, 32'hFF800000);
        check("ovf_out_flags", out_flags, 2'b10);
        check("ovf_sticky", sticky_ovf, 1);
        check("ovf_count", count, 1);
        drive(1'b1, 32'h00000010, 1'b0, 1'b1);
        tick();
        check("unf_out_data", out_data, 32'h00000000);
        check("unf_out_flags", out_flags, 2'b01);
        check("unf_sticky", sticky_unf, 1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0;
        check("empty_count", count, 0);
        check("empty_out_valid", out_valid, 0);

        // Fill to DEPTH with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, f_in[i], f_ovf[i], f_unf[i]);
            tick();
        end
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        drive(1'b1, 32'h11111111, 1'b0, 1'b0);
        tick();
        tick();
        check("held_count", count, 4);
        check("held_head", out_data, f_exp[0]);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_data%0d", i), out_data, f_exp[i]);
            check($sformatf("drain_flags%0d", i), out_flags, f_flg[i]);
            tick();
        end
        out_ready = 1'b0;
        check("drain_count", count, 0);
        check("drain_out_valid", out_valid, 0);

        // Refill across the pointer wrap and drain again.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h01000000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("refill_count", count, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("refill_data%0d", i), out_data, 32'h01000000 + 32'(i));
            tick();
        end
        out_ready = 1'b0;
        check("refill_empty", count, 0);

        // Streaming with occupancy 2: output trails input by two entries.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h42000000 + 32'(k), 1'b0, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h42000000 + 32'(k + 2), 1'b0, 1'b0);
            check($sformatf("stream_data%0d", k), out_data, 32'h42000000 + 32'(k));
            tick();
            check($sformatf("stream_count%0d", k), count, 2);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 10; k < 12; k++) begin
            check($sformatf("stream_tail%0d", k), out_data, 32'h42000000 + 32'(k));
            tick();
        end
        out_ready = 1'b0;
        check("stream_empty", count, 0);

`ifdef FPMUL_RESULT_STATS_EN
        check("stats_ovf_cnt", ovf_cnt, 2);
        check("stats_unf_cnt", unf_cnt, 3);
`endif

        // Clear racing a setting push: sticky set wins, counters cleared.
        flag_clear = 1'b1;
        drive(1'b1, 32'h00000010, 1'b0, 1'b1);
        tick();
        flag_clear = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("clr_push_unf", sticky_unf, 1);
        check("clr_push_ovf", sticky_ovf, 0);
`ifdef FPMUL_RESULT_STATS_EN
        check("clr_push_unf_cnt", unf_cnt, 0);
        check("clr_push_ovf_cnt", ovf_cnt, 0);
`endif
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        check("clr_alone_unf", sticky_unf, 0);
`ifdef FPMUL_RESULT_STATS_EN
        drive(1'b1, 32'h80000010, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("stats_unf_inc", unf_cnt, 1);
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        check("stats_unf_clr", unf_cnt, 0);
`endif
        check("pre_rst_valid", out_valid, 1);

        // Asynchronous reset between edges discards queued entries.
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_out_data", out_data, 0);
        rst = 1'b0;
        tick();
        check("post_rst_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
